// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush arbiter and halt owner
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  id_rs_addr,
  input  logic [3:0]  id_rt_addr,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        hlt_ID,
  input  logic        ex_re_mem,
  input  logic [3:0]  ex_dst_addr,
  input  logic        mem_access,
  input  logic        mem_rdy,
  input  logic        br_taken_MEM,
  output logic        stall_pc,
  output logic        stall_IF_ID,
  output logic        stall_ID_EX,
  output logic        stall_EX_MEM,
  output logic        stall_MEM_WB,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        flush_EX_MEM,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [2:0] LP_DEPTH   = 3'(DRAIN_DEPTH);

  state_t     r_state;
  state_t     w_next_state;
  state_t     w_eff_state;
  logic       r_ret_drain;
  logic       w_next_ret_drain;
  logic [2:0] r_drain_cnt;
  logic [2:0] w_next_drain_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;
  logic       w_memwait;
  logic       w_load_use;

  assign w_memwait  = mem_access & ~mem_rdy;
  assign w_load_use = ex_re_mem && (ex_dst_addr != 4'd0) &&
                      ((id_uses_rs && (id_rs_addr == ex_dst_addr)) ||
                       (id_uses_rt && (id_rt_addr == ex_dst_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_ret_drain <= 1'b0;
      r_drain_cnt <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_ret_drain <= w_next_ret_drain;
      r_drain_cnt <= w_next_drain_cnt;
    end
  end

  // MEM_WAIT resumes as RUN or DRAIN in the cycle the access completes.
  always_comb begin
    w_next_state     = r_state;
    w_next_ret_drain = r_ret_drain;
    w_next_drain_cnt = r_drain_cnt;
    w_eff_state      = r_state;
    stall_pc         = 1'b0;
    stall_IF_ID      = 1'b0;
    stall_ID_EX      = 1'b0;
    stall_EX_MEM     = 1'b0;
    stall_MEM_WB     = 1'b0;
    flush_IF_ID      = 1'b0;
    flush_ID_EX      = 1'b0;
    flush_EX_MEM     = 1'b0;
    if (r_state == ST_MEM_WAIT) begin
      w_eff_state = r_ret_drain ? ST_DRAIN : ST_RUN;
    end
    if (!rst_n) begin
      w_next_state = ST_RUN;
    end else if (r_state == ST_HALTED) begin
      stall_pc     = 1'b1;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      stall_MEM_WB = 1'b1;
    end else if (w_memwait) begin
      stall_pc     = 1'b1;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      stall_MEM_WB = 1'b1;
      w_next_state = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) begin
        w_next_ret_drain = (r_state == ST_DRAIN);
      end
    end else if (br_taken_MEM) begin
      flush_IF_ID      = 1'b1;
      flush_ID_EX      = 1'b1;
      flush_EX_MEM     = 1'b1;
      w_next_state     = ST_RUN;
      w_next_ret_drain = 1'b0;
      w_next_drain_cnt = 3'd0;
    end else if (w_eff_state == ST_DRAIN) begin
      stall_pc         = 1'b1;
      stall_IF_ID      = 1'b1;
      flush_ID_EX      = 1'b1;
      w_next_ret_drain = 1'b0;
      w_next_drain_cnt = r_drain_cnt - 3'd1;
      w_next_state     = (r_drain_cnt <= 3'd1) ? ST_HALTED : ST_DRAIN;
    end else if (w_load_use) begin
      stall_pc     = 1'b1;
      stall_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      w_next_state = ST_RUN;
    end else if (hlt_ID) begin
      w_next_state     = ST_DRAIN;
      w_next_ret_drain = 1'b0;
      w_next_drain_cnt = LP_DEPTH;
    end else begin
      w_next_state = ST_RUN;
    end
  end

  // Wait counter saturates so a stuck memory cannot wrap back below the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else if (r_state != ST_HALTED) begin
      if (w_memwait) begin
        if (r_wait_cnt != 8'hFF) begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
        end
        if ((r_wait_cnt + 8'd1) == LP_TIMEOUT) begin
          r_mem_err <= 1'b1;
        end
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

  assign halted  = (r_state == ST_HALTED);
  assign mem_err = r_mem_err;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_events;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'h0000;
      r_flush_events <= 16'h0000;
    end else if (r_state != ST_HALTED) begin
      if (stall_pc && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (flush_IF_ID && (r_flush_events != 16'hFFFF)) begin
        r_flush_events <= r_flush_events + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = 16'h0000;
  assign flush_events = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int TO    = 5;
  localparam int DEPTH = 3;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  id_rs_addr = 4'd0, id_rt_addr = 4'd0, ex_dst_addr = 4'd0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, hlt_ID = 1'b0, ex_re_mem = 1'b0;
  logic        mem_access = 1'b0, mem_rdy = 1'b0, br_taken_MEM = 1'b0;
  logic        stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, halted, mem_err;
  logic [15:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .DRAIN_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .hlt_ID(hlt_ID), .ex_re_mem(ex_re_mem), .ex_dst_addr(ex_dst_addr),
    .mem_access(mem_access), .mem_rdy(mem_rdy), .br_taken_MEM(br_taken_MEM),
    .stall_pc(stall_pc), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
    .halted(halted), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pipeline status expressed as halted flag plus remaining drain cycles.
  bit       m_halted;
  int       m_drain_left;
  int       m_wait_cnt;
  bit       m_err;
  int       m_stall_cnt;
  int       m_flush_cnt;
  logic [4:0] e_stall;
  logic [2:0] e_flush;

  function automatic logic [4:0] dut_stall();
    return {stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB};
  endfunction

  function automatic logic [2:0] dut_flush();
    return {flush_IF_ID, flush_ID_EX, flush_EX_MEM};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard_lu();
    return ex_re_mem && (ex_dst_addr != 0) &&
           ((id_uses_rs && id_rs_addr == ex_dst_addr) || (id_uses_rt && id_rt_addr == ex_dst_addr));
  endfunction

  task automatic model_reset();
    m_halted = 0; m_drain_left = 0; m_wait_cnt = 0; m_err = 0;
    m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  task automatic model_outputs();
    bit mw;
    mw = mem_access && !mem_rdy;
    e_stall = 5'b00000;
    e_flush = 3'b000;
    if (!rst_n)                 ;
    else if (m_halted)          e_stall = 5'b11111;
    else if (mw)                e_stall = 5'b11111;
    else if (br_taken_MEM)      e_flush = 3'b111;
    else if (m_drain_left > 0 || hazard_lu()) begin
      e_stall = 5'b11000;
      e_flush = 3'b010;
    end
  endtask

  task automatic compare();
    model_outputs();
    chk("stalls", 32'(dut_stall()), 32'(e_stall));
    chk("flushes", 32'(dut_flush()), 32'(e_flush));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    chk("stall_cycles", 32'(stall_cycles), PERF ? 32'(m_stall_cnt) : 32'd0);
    chk("flush_events", 32'(flush_events), PERF ? 32'(m_flush_cnt) : 32'd0);
  endtask

  task automatic model_step();
    bit mw;
    mw = mem_access && !mem_rdy;
    if (m_halted) return;
    if (e_stall[4] && m_stall_cnt < 65535) m_stall_cnt++;
    if (e_flush[2] && m_flush_cnt < 65535) m_flush_cnt++;
    if (mw) begin
      if (m_wait_cnt < 255) m_wait_cnt++;
      if (m_wait_cnt == TO) m_err = 1;
    end else begin
      m_wait_cnt = 0;
      if (br_taken_MEM) m_drain_left = 0;
      else if (m_drain_left > 0) begin
        if (m_drain_left == 1) m_halted = 1;
        m_drain_left--;
      end else if (!hazard_lu() && hlt_ID) m_drain_left = DEPTH;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs_addr = 0; id_rt_addr = 0; ex_dst_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0; hlt_ID = 0; ex_re_mem = 0;
    mem_access = 0; mem_rdy = 0; br_taken_MEM = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input logic [4:0] s, input logic [2:0] f);
    #1;
    chk({name, "_stall"}, 32'(dut_stall()), 32'(s));
    chk({name, "_flush"}, 32'(dut_flush()), 32'(f));
  endtask

  initial begin
    @(negedge clk);
    clear_inputs();
    do_reset();
    lit("reset_idle", 5'b00000, 3'b000);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    cycle();

    // load-use on rt=r3, then ex_dst_addr=0
    ex_re_mem = 1; ex_dst_addr = 4'd3; id_uses_rt = 1; id_rt_addr = 4'd3;
    lit("lu_r3", 5'b11000, 3'b010);
    cycle();
    clear_inputs();
    lit("lu_after", 5'b00000, 3'b000);
    cycle();
    ex_re_mem = 1; ex_dst_addr = 4'd0; id_uses_rt = 1; id_rt_addr = 4'd0;
    lit("lu_r0", 5'b00000, 3'b000);
    cycle();
    clear_inputs();

    // four memwait cycles then ready
    mem_access = 1;
    for (int i = 0; i < 4; i++) begin
      lit("mw4", 5'b11111, 3'b000);
      cycle();
    end
    mem_rdy = 1;
    lit("mw4_rdy", 5'b00000, 3'b000);
    cycle();
    clear_inputs();
    lit("mw4_run", 5'b00000, 3'b000);
    chk("mw4_err", 32'(mem_err), 32'd0);
    cycle();

    // timeout after the fifth wait cycle, sticky after ready
    mem_access = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("to_err_edge", 32'(mem_err), (i >= 5) ? 32'd1 : 32'd0);
      cycle();
    end
    mem_rdy = 1;
    cycle();
    clear_inputs();
    #1;
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    cycle();

    // branch coincident with load-use
    do_reset();
    br_taken_MEM = 1; ex_re_mem = 1; ex_dst_addr = 4'd5; id_uses_rs = 1; id_rs_addr = 4'd5;
    lit("br_lu", 5'b00000, 3'b111);
    cycle();
    clear_inputs();
    #1;
    chk("br_flush_events", 32'(flush_events), PERF ? 32'd1 : 32'd0);
    cycle();

    // halt drain
    hlt_ID = 1;
    lit("hlt_dec", 5'b00000, 3'b000);
    cycle();
    hlt_ID = 0;
    for (int i = 0; i < DEPTH; i++) begin
      lit("drain", 5'b11000, 3'b010);
      chk("drain_halted", 32'(halted), 32'd0);
      cycle();
    end
    lit("halted_stalls", 5'b11111, 3'b000);
    chk("halted_flag", 32'(halted), 32'd1);
    br_taken_MEM = 1; mem_access = 1;
    cycle();
    clear_inputs();
    chk("halted_hold", 32'(halted), 32'd1);
    cycle();

    // branch cancels a drain in its second cycle
    do_reset();
    hlt_ID = 1;
    cycle();
    hlt_ID = 0;
    cycle();
    br_taken_MEM = 1;
    lit("drain_br", 5'b00000, 3'b111);
    cycle();
    br_taken_MEM = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      lit("drain_br_run", 5'b00000, 3'b000);
      chk("drain_br_halted", 32'(halted), 32'd0);
      cycle();
    end

    // asynchronous reset while waiting on memory
    mem_access = 1;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mw_stall", 32'(dut_stall()), 32'd0);
    chk("rst_mw_flush", 32'(dut_flush()), 32'd0);
    chk("rst_mw_halted", 32'(halted), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    cycle();

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        clear_inputs();
        do_reset();
      end
      id_rs_addr   = 4'($urandom_range(0, 3));
      id_rt_addr   = 4'($urandom_range(0, 3));
      ex_dst_addr  = 4'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_re_mem    = 1'($urandom_range(0, 1));
      hlt_ID       = ($urandom_range(0, 11) == 0);
      br_taken_MEM = ($urandom_range(0, 6) == 0);
      mem_access   = ($urandom_range(0, 2) == 0);
      mem_rdy      = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
